// File: rtl/riscv_pkg.sv
// Shared definitions for the tiny-riscv load/store path: RV32I funct3
// encodings for loads and stores, the LSU state type and access-size helpers.
package riscv_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size field (funct3[1:0])
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // Byte lanes touched by an access of the given size at the given lane.
    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << lane;
            SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational formatting for the LSU: store data replication and byte
// enables, misalignment / illegal-funct3 detection for the offered op, and
// byte-lane extraction plus sign/zero extension of load response data.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        op_is_store,
    input  logic [2:0]  op_funct3,
    input  logic [1:0]  op_lane,
    input  logic [31:0] op_wdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic        misaligned,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [7:0]  rd_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Split the response word into byte lanes so selection is a plain mux.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
        assign rd_bytes[gi] = ld_rdata[8*gi +: 8];
    end

    assign sel_byte = rd_bytes[ld_lane];
    assign sel_half = {rd_bytes[{ld_lane[1], 1'b1}], rd_bytes[{ld_lane[1], 1'b0}]};

    // Store data replication: every lane carries the data so the byte
    // enables alone pick where it lands.
    always_comb begin
        st_wdata = op_wdata;
        st_be    = size_to_be(op_funct3[1:0], op_lane);
        case (op_funct3)
            F3_SB:   st_wdata = {4{op_wdata[7:0]}};
            F3_SH:   st_wdata = {2{op_wdata[15:0]}};
            default: st_wdata = op_wdata;
        endcase
    end

    // Reject ops the bus cannot express: unaligned halves/words and
    // funct3 codes outside RV32I.
    always_comb begin
        misaligned = 1'b0;
        case (op_funct3[1:0])
            SIZE_H:  misaligned = op_lane[0];
            SIZE_W:  misaligned = (op_lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (op_is_store) begin
            illegal = (op_funct3 >= 3'b011);
        end else begin
            illegal = (op_funct3 == 3'b011) || (op_funct3 == 3'b110) || (op_funct3 == 3'b111);
        end
    end

    // Load extraction and extension; LW passes the word through.
    always_comb begin
        ld_result = ld_rdata;
        case (ld_funct3)
            F3_LB:   ld_result = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   ld_result = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  ld_result = {24'd0, sel_byte};
            F3_LHU:  ld_result = {16'd0, sel_half};
            default: ld_result = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, runs the req/gnt/rvalid
// handshake with data memory and returns extended load data. The control
// block can squash an op through lsu_en at any point; a squashed load still
// consumes its response but never raises ld_valid.
module lsu
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_en,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [4:0]  op_rd,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        mem_exc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_reg, state_next;

    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [4:0]  rd_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  lane_reg;
    logic        kill_reg, kill_next;
    logic        exc_reg, exc_next;
    logic        ld_valid_reg, ld_valid_next;
    logic [31:0] ld_data_reg;
    logic [4:0]  ld_rd_reg;

    logic        accept;
    logic        capture_ld;

    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        misaligned;
    logic        illegal;
    logic [31:0] ld_result;

    lsu_align u_align (
        .op_is_store (op_is_store),
        .op_funct3   (op_funct3),
        .op_lane     (op_addr[1:0]),
        .op_wdata    (op_wdata),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .misaligned  (misaligned),
        .illegal     (illegal),
        .ld_funct3   (funct3_reg),
        .ld_lane     (lane_reg),
        .ld_rdata    (mem_rdata),
        .ld_result   (ld_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, squash tracking and pulse generation.
    always_comb begin
        state_next    = state_reg;
        accept        = 1'b0;
        exc_next      = 1'b0;
        kill_next     = kill_reg;
        ld_valid_next = 1'b0;
        capture_ld    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (op_valid && lsu_en) begin
                    if (misaligned || illegal) begin
                        exc_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // A grant wins over a same-cycle squash: the bus has already
                // taken the request, so a load must still drain its response.
                if (mem_gnt) begin
                    if (we_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                        if (!lsu_en) begin
                            kill_next = 1'b1;
                        end
                    end
                end else if (!lsu_en) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (!lsu_en) begin
                    kill_next = 1'b1;
                end
                if (mem_rvalid) begin
                    state_next    = IDLE;
                    capture_ld    = !kill_reg && lsu_en;
                    ld_valid_next = !kill_reg && lsu_en;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operation capture on accept, load result capture on a live response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= 32'd0;
            be_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
            we_reg       <= 1'b0;
            rd_reg       <= 5'd0;
            funct3_reg   <= 3'd0;
            lane_reg     <= 2'd0;
            kill_reg     <= 1'b0;
            exc_reg      <= 1'b0;
            ld_valid_reg <= 1'b0;
            ld_data_reg  <= 32'd0;
            ld_rd_reg    <= 5'd0;
        end else begin
            kill_reg     <= kill_next;
            exc_reg      <= exc_next;
            ld_valid_reg <= ld_valid_next;
            if (accept) begin
                addr_reg   <= {op_addr[31:2], 2'b00};
                be_reg     <= st_be;
                wdata_reg  <= op_is_store ? st_wdata : 32'd0;
                we_reg     <= op_is_store;
                rd_reg     <= op_rd;
                funct3_reg <= op_funct3;
                lane_reg   <= op_addr[1:0];
            end
            if (capture_ld) begin
                ld_data_reg <= ld_result;
                ld_rd_reg   <= rd_reg;
            end
        end
    end

    // Bus request follows the state register so reset drops it at once.
    assign op_ready  = (state_reg == IDLE);
    assign mem_req   = (state_reg == REQ);
    assign mem_we    = we_reg && (state_reg == REQ);
    assign mem_be    = be_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_exc   = exc_reg;
    assign ld_valid  = ld_valid_reg;
    assign ld_data   = ld_data_reg;
    assign ld_rd     = ld_rd_reg;

endmodule

// File: tb/tb_lsu.sv
// Bench for the load/store unit: a table of directed ops with hand-computed
// expectations, hand-written squash/reset sequences, and randomized ops
// checked against an arithmetic reference model of the access rules.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_en;
    logic        op_valid;
    logic        op_ready;
    logic        op_is_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        mem_exc;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_exc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t vecs[$];

    lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lsu_en      (lsu_en),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_is_store (op_is_store),
        .op_funct3   (op_funct3),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .op_rd       (op_rd),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_rd       (ld_rd),
        .mem_exc     (mem_exc),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd,
                                input logic [31:0] rdata, input int gd, input int rvd,
                                input logic exc, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] eld);
        vec_t v;
        v.is_store = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.rdata = rdata; v.gnt_dly = gd; v.rv_dly = rvd; v.exp_exc = exc;
        v.exp_be = be; v.exp_wdata = ewd; v.exp_ld = eld;
        return v;
    endfunction

    // Reference model: access rules in plain arithmetic on sizes and offsets.
    function automatic vec_t model(input vec_t vin);
        vec_t        v;
        int          size;
        int          lane;
        logic        bad_f3;
        logic [31:0] val;
        v    = vin;
        lane = int'(v.addr % 32'd4);
        case (int'(v.f3) % 4)
            0:       size = 1;
            1:       size = 2;
            default: size = 4;
        endcase
        if (v.is_store) bad_f3 = (int'(v.f3) >= 3);
        else            bad_f3 = (int'(v.f3) == 3) || (int'(v.f3) >= 6);
        v.exp_exc = bad_f3 || ((lane % size) != 0);
        v.exp_be  = 4'(((1 << size) - 1) << lane);
        if (size == 1)      v.exp_wdata = (v.wdata % 32'd256) * 32'h01010101;
        else if (size == 2) v.exp_wdata = (v.wdata % 32'd65536) * 32'h00010001;
        else                v.exp_wdata = v.wdata;
        val = v.rdata >> (8 * lane);
        if (size == 1) begin
            val = val % 32'd256;
            if (int'(v.f3) < 4 && val >= 32'd128) val = val - 32'd256;
        end else if (size == 2) begin
            val = val % 32'd65536;
            if (int'(v.f3) < 4 && val >= 32'd32768) val = val - 32'd65536;
        end
        v.exp_ld = val;
        return v;
    endfunction

    task automatic offer(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        op_valid = 1'b1; op_is_store = st; op_funct3 = f3;
        op_addr = addr; op_wdata = wdata; op_rd = rd;
    endtask

    // One complete transaction with a scripted memory responder.
    task automatic run_op(input vec_t v);
        $display("op %s f3=%0d addr=%h wdata=%h rd=%0d gnt_dly=%0d rv_dly=%0d",
                 v.is_store ? "ST" : "LD", v.f3, v.addr, v.wdata, v.rd, v.gnt_dly, v.rv_dly);
        chk("op_ready_idle", 32'(op_ready), 32'd1);
        offer(v.is_store, v.f3, v.addr, v.wdata, v.rd);
        tick();
        op_valid = 1'b0;
        if (v.exp_exc) begin
            chk("exc_pulse", 32'(mem_exc), 32'd1);
            chk("exc_no_req", 32'(mem_req), 32'd0);
            tick();
            chk("exc_single", 32'(mem_exc), 32'd0);
            chk("exc_no_req2", 32'(mem_req), 32'd0);
            return;
        end
        chk("no_exc", 32'(mem_exc), 32'd0);
        for (int k = 0; k <= v.gnt_dly; k++) begin
            chk("req_high", 32'(mem_req), 32'd1);
            chk("req_addr", mem_addr, {v.addr[31:2], 2'b00});
            chk("req_we", 32'(mem_we), 32'(v.is_store));
            if (v.is_store) begin
                chk("req_be", 32'(mem_be), 32'(v.exp_be));
                chk("req_wdata", mem_wdata, v.exp_wdata);
            end
            if (k == v.gnt_dly) mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
        end
        if (v.is_store) begin
            chk("st_req_drop", 32'(mem_req), 32'd0);
            chk("st_ready", 32'(op_ready), 32'd1);
            chk("st_no_ldv", 32'(ld_valid), 32'd0);
            return;
        end
        chk("ld_busy", 32'(op_ready), 32'd0);
        for (int k = 1; k < v.rv_dly; k++) begin
            chk("ld_wait_nov", 32'(ld_valid), 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk("ld_valid", 32'(ld_valid), 32'd1);
        chk("ld_data", ld_data, v.exp_ld);
        chk("ld_rd", 32'(ld_rd), 32'(v.rd));
        chk("ld_ready", 32'(op_ready), 32'd1);
        tick();
        chk("ld_valid_single", 32'(ld_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; lsu_en = 1'b1; op_valid = 1'b0; op_is_store = 1'b0;
        op_funct3 = 3'd0; op_addr = 32'd0; op_wdata = 32'd0; op_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        #1;
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_ldv", 32'(ld_valid), 32'd0);
        chk("rst_exc", 32'(mem_exc), 32'd0);
        chk("rst_lddata", ld_data, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed table with hand-derived expectations.
        vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 0, 4'b1111, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, 1, 0, 4'b1000, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 1, 1, 0, 4'b1100, 32'hABCDABCD, 0));
        vecs.push_back(mk(0, 3'b000, 32'h303, 0, 5,  32'h80FF7F01, 0, 1, 0, 0, 0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 3'b100, 32'h303, 0, 6,  32'h80FF7F01, 0, 1, 0, 0, 0, 32'h00000080));
        vecs.push_back(mk(0, 3'b001, 32'h302, 0, 7,  32'h80FF7F01, 0, 1, 0, 0, 0, 32'hFFFF80FF));
        vecs.push_back(mk(0, 3'b101, 32'h300, 0, 8,  32'h80FF7F01, 0, 1, 0, 0, 0, 32'h00007F01));
        vecs.push_back(mk(0, 3'b000, 32'h301, 0, 9,  32'h80FF7F01, 0, 1, 0, 0, 0, 32'h0000007F));
        vecs.push_back(mk(0, 3'b010, 32'h400, 0, 10, 32'h12345678, 3, 2, 0, 0, 0, 32'h12345678));
        vecs.push_back(mk(0, 3'b010, 32'h102, 0, 11, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h101, 32'h5555, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'h100, 0, 12, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'h100, 32'h1, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // lsu_en low in IDLE: nothing accepted, not even an illegal op.
        $display("seq idle_squash");
        lsu_en = 1'b0;
        offer(0, 3'b010, 32'h11, 0, 3);
        tick();
        op_valid = 1'b0; lsu_en = 1'b1;
        chk("idle_sq_req", 32'(mem_req), 32'd0);
        chk("idle_sq_exc", 32'(mem_exc), 32'd0);
        chk("idle_sq_ready", 32'(op_ready), 32'd1);

        // Squash in REQ without grant: request withdrawn, stray rvalid ignored.
        $display("seq req_squash");
        offer(0, 3'b010, 32'h20, 0, 4);
        tick();
        op_valid = 1'b0;
        chk("req_sq_req", 32'(mem_req), 32'd1);
        lsu_en = 1'b0;
        tick();
        lsu_en = 1'b1;
        chk("req_sq_drop", 32'(mem_req), 32'd0);
        chk("req_sq_ready", 32'(op_ready), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rv_ldv", 32'(ld_valid), 32'd0);

        // Squash in WAIT: response consumed, no ld_valid, next op normal.
        $display("seq wait_squash");
        offer(0, 3'b010, 32'h30, 0, 9);
        tick();
        op_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; lsu_en = 1'b0;
        tick();
        lsu_en = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BADBEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("wait_sq_ldv", 32'(ld_valid), 32'd0);
        chk("wait_sq_ready", 32'(op_ready), 32'd1);
        tick();
        chk("wait_sq_ldv2", 32'(ld_valid), 32'd0);
        run_op(mk(0, 3'b101, 32'h502, 0, 13, 32'hBEEF1234, 0, 1, 0, 0, 0, 32'h0000BEEF));

        // Grant and squash in the same cycle on a load: goes to WAIT killed.
        $display("seq gnt_squash");
        offer(0, 3'b010, 32'h40, 0, 14);
        tick();
        op_valid = 1'b0; mem_gnt = 1'b1; lsu_en = 1'b0;
        tick();
        mem_gnt = 1'b0; lsu_en = 1'b1;
        chk("gnt_sq_req", 32'(mem_req), 32'd0);
        chk("gnt_sq_wait", 32'(op_ready), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_rvalid = 1'b0;
        chk("gnt_sq_ldv", 32'(ld_valid), 32'd0);
        chk("gnt_sq_ready", 32'(op_ready), 32'd1);

        // Reset while a load waits for its response.
        $display("seq reset_in_wait");
        offer(0, 3'b010, 32'h7C, 0, 15);
        tick();
        op_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw_ready", 32'(op_ready), 32'd1);
        chk("rw_req", 32'(mem_req), 32'd0);
        chk("rw_be", 32'(mem_be), 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        chk("rw_lddata", ld_data, 32'd0);
        chk("rw_ldrd", 32'(ld_rd), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h33334444;
        tick();
        mem_rvalid = 1'b0;
        chk("rw_stray_ldv", 32'(ld_valid), 32'd0);
        chk("rw_ready2", 32'(op_ready), 32'd1);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            v.is_store = 1'($urandom_range(0, 1));
            v.f3       = 3'($urandom_range(0, 7));
            v.addr     = $urandom & 32'h0000_0FFF;
            v.wdata    = $urandom;
            v.rd       = 5'($urandom_range(1, 31));
            v.rdata    = $urandom;
            v.gnt_dly  = int'($urandom_range(0, 2));
            v.rv_dly   = int'($urandom_range(1, 3));
            v = model(v);
            run_op(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
